// File: rtl/bali_isa_pkg.sv
// bali_isa_pkg: opcode/ALU constants, decode record types and argument-count lookup
// shared by the bytecode decode stage and its opcode table.
package bali_isa_pkg;

    localparam logic [7:0] OP_NOP       = 8'h00;
    localparam logic [7:0] OP_ICONST_M1 = 8'h02;
    localparam logic [7:0] OP_ICONST_5  = 8'h08;
    localparam logic [7:0] OP_BIPUSH    = 8'h10;
    localparam logic [7:0] OP_SIPUSH    = 8'h11;
    localparam logic [7:0] OP_LDC       = 8'h12;
    localparam logic [7:0] OP_ILOAD     = 8'h15;
    localparam logic [7:0] OP_ILOAD_0   = 8'h1a;
    localparam logic [7:0] OP_ILOAD_3   = 8'h1d;
    localparam logic [7:0] OP_ALOAD_0   = 8'h2a;
    localparam logic [7:0] OP_ALOAD_3   = 8'h2d;
    localparam logic [7:0] OP_IALOAD    = 8'h2e;
    localparam logic [7:0] OP_BALOAD    = 8'h33;
    localparam logic [7:0] OP_ISTORE    = 8'h36;
    localparam logic [7:0] OP_ISTORE_0  = 8'h3b;
    localparam logic [7:0] OP_ISTORE_3  = 8'h3e;
    localparam logic [7:0] OP_ASTORE_0  = 8'h4b;
    localparam logic [7:0] OP_ASTORE_3  = 8'h4e;
    localparam logic [7:0] OP_IASTORE   = 8'h4f;
    localparam logic [7:0] OP_BASTORE   = 8'h54;
    localparam logic [7:0] OP_POP       = 8'h57;
    localparam logic [7:0] OP_DUP       = 8'h59;
    localparam logic [7:0] OP_IADD      = 8'h60;
    localparam logic [7:0] OP_ISUB      = 8'h64;
    localparam logic [7:0] OP_IMUL      = 8'h68;
    localparam logic [7:0] OP_IDIV      = 8'h6c;
    localparam logic [7:0] OP_IREM      = 8'h70;
    localparam logic [7:0] OP_INEG      = 8'h74;
    localparam logic [7:0] OP_ISHL      = 8'h78;
    localparam logic [7:0] OP_ISHR      = 8'h7a;
    localparam logic [7:0] OP_IAND      = 8'h7e;
    localparam logic [7:0] OP_IOR       = 8'h80;
    localparam logic [7:0] OP_IXOR      = 8'h82;
    localparam logic [7:0] OP_IINC      = 8'h84;
    localparam logic [7:0] OP_IFEQ      = 8'h99;
    localparam logic [7:0] OP_IFLE      = 8'h9e;
    localparam logic [7:0] OP_IF_ICMPEQ = 8'h9f;
    localparam logic [7:0] OP_IF_ICMPLE = 8'ha4;
    localparam logic [7:0] OP_GOTO      = 8'ha7;
    localparam logic [7:0] OP_IRETURN   = 8'hac;
    localparam logic [7:0] OP_ARETURN   = 8'hb0;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_MUL = 4'b0010;
    localparam logic [3:0] ALU_DIV = 4'b0011;
    localparam logic [3:0] ALU_REM = 4'b0100;
    localparam logic [3:0] ALU_NEG = 4'b0101;
    localparam logic [3:0] ALU_SHL = 4'b1100;
    localparam logic [3:0] ALU_SHR = 4'b1101;
    localparam logic [3:0] ALU_AND = 4'b1111;
    localparam logic [3:0] ALU_OR  = 4'b1000;
    localparam logic [3:0] ALU_XOR = 4'b1001;

    typedef enum logic [1:0] {S_OP, S_ARG1, S_ARG2} state_e;

    // How the operand/argidx fields are built from the argument bytes.
    typedef enum logic [2:0] {
        OK_NONE, OK_SEXT8, OK_SEXT16, OK_ZEXT8, OK_IDX, OK_IINC, OK_CONST, OK_IDXN
    } opnd_kind_e;

    typedef struct packed {
        logic       legal;
        logic [1:0] argc;
        logic [3:0] aluop;
        logic       isaluop;
        logic [1:0] stackargs;
        logic       stackwb;
        logic       constpush;
        opnd_kind_e kind;
        logic [1:0] idx_n;
        logic [3:0] cval;
    } op_class_t;

    // Width-independent part of a FIFO entry; pc and operand are stored alongside.
    typedef struct packed {
        logic [7:0] opcode;
        logic [1:0] len;
        logic [3:0] aluop;
        logic       isaluop;
        logic [1:0] stackargs;
        logic       stackwb;
        logic       constpush;
        logic [7:0] argidx;
        logic       illegal;
    } decode_rec_t;

    function automatic logic [1:0] argc_of(input logic [7:0] op);
        return (op == OP_BIPUSH || op == OP_LDC || op == OP_ILOAD || op == OP_ISTORE) ? 2'd1 :
               (op == OP_SIPUSH || op == OP_IINC || op == OP_GOTO ||
                (op >= OP_IFEQ && op <= OP_IF_ICMPLE)) ? 2'd2 : 2'd0;
    endfunction

endpackage

// File: rtl/bytecode_decode_stage_opcode_table.sv
// opcode_table: combinational opcode-to-class lookup; unknown opcodes come back
// with legal=0 and every other field zero.
module opcode_table
    import bali_isa_pkg::*;
(
    input  logic [7:0] i_opcode,
    output op_class_t  o_class
);

    always_comb begin
        o_class = '0;
        o_class.legal = 1'b1;
        o_class.argc = argc_of(i_opcode);
        case (i_opcode) inside
            OP_NOP: o_class.legal = 1'b1;
            [OP_ICONST_M1:OP_ICONST_5]: begin
                o_class.stackwb = 1'b1;
                o_class.constpush = 1'b1;
                o_class.kind = OK_CONST;
                o_class.cval = i_opcode[3:0] - 4'd3;
            end
            OP_BIPUSH: begin
                o_class.stackwb = 1'b1;
                o_class.constpush = 1'b1;
                o_class.kind = OK_SEXT8;
            end
            OP_SIPUSH: begin
                o_class.stackwb = 1'b1;
                o_class.constpush = 1'b1;
                o_class.kind = OK_SEXT16;
            end
            OP_LDC: begin
                o_class.stackwb = 1'b1;
                o_class.kind = OK_ZEXT8;
            end
            OP_ILOAD: begin
                o_class.stackwb = 1'b1;
                o_class.kind = OK_IDX;
            end
            // _n forms: ILOAD_0/ALOAD_0 sit at low bits 2'b10, stores at 2'b11
            [OP_ILOAD_0:OP_ILOAD_3], [OP_ALOAD_0:OP_ALOAD_3]: begin
                o_class.stackwb = 1'b1;
                o_class.kind = OK_IDXN;
                o_class.idx_n = i_opcode[1:0] - 2'd2;
            end
            OP_IALOAD, OP_BALOAD: begin
                o_class.stackargs = 2'd2;
                o_class.stackwb = 1'b1;
            end
            OP_ISTORE: begin
                o_class.stackargs = 2'd1;
                o_class.kind = OK_IDX;
            end
            [OP_ISTORE_0:OP_ISTORE_3], [OP_ASTORE_0:OP_ASTORE_3]: begin
                o_class.stackargs = 2'd1;
                o_class.kind = OK_IDXN;
                o_class.idx_n = i_opcode[1:0] - 2'd3;
            end
            OP_IASTORE, OP_BASTORE: o_class.stackargs = 2'd3;
            OP_POP, OP_IRETURN, OP_ARETURN: o_class.stackargs = 2'd1;
            OP_DUP: begin
                o_class.stackargs = 2'd1;
                o_class.stackwb = 1'b1;
            end
            OP_IADD, OP_ISUB, OP_IMUL, OP_IDIV, OP_IREM, OP_ISHL, OP_ISHR, OP_IAND, OP_IOR, OP_IXOR: begin
                o_class.stackargs = 2'd2;
                o_class.stackwb = 1'b1;
                o_class.isaluop = 1'b1;
            end
            OP_INEG: begin
                o_class.stackargs = 2'd1;
                o_class.stackwb = 1'b1;
                o_class.isaluop = 1'b1;
            end
            OP_IINC: begin
                o_class.isaluop = 1'b1;
                o_class.kind = OK_IINC;
            end
            [OP_IFEQ:OP_IFLE]: begin
                o_class.stackargs = 2'd1;
                o_class.kind = OK_SEXT16;
            end
            [OP_IF_ICMPEQ:OP_IF_ICMPLE]: begin
                o_class.stackargs = 2'd2;
                o_class.kind = OK_SEXT16;
            end
            OP_GOTO: o_class.kind = OK_SEXT16;
            default: o_class.legal = 1'b0;
        endcase
        o_class.aluop = (i_opcode == OP_ISUB) ? ALU_SUB :
                        (i_opcode == OP_IMUL) ? ALU_MUL :
                        (i_opcode == OP_IDIV) ? ALU_DIV :
                        (i_opcode == OP_IREM) ? ALU_REM :
                        (i_opcode == OP_INEG) ? ALU_NEG :
                        (i_opcode == OP_ISHL) ? ALU_SHL :
                        (i_opcode == OP_ISHR) ? ALU_SHR :
                        (i_opcode == OP_IAND) ? ALU_AND :
                        (i_opcode == OP_IOR)  ? ALU_OR  :
                        (i_opcode == OP_IXOR) ? ALU_XOR : ALU_ADD;
    end

endmodule

// File: rtl/bytecode_decode_stage.sv
// bytecode_decode_stage: assembles JVM bytecode bytes into decoded instruction
// records and queues them in a first-word fall-through FIFO for execute.
module bytecode_decode_stage
    import bali_isa_pkg::*;
#(
    parameter int OPW   = 32,
    parameter int PCW   = 16,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic [7:0]     in_byte,
    output logic           in_ready,
    input  logic           flush,
    input  logic [PCW-1:0] flush_pc,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [7:0]     out_opcode,
    output logic [PCW-1:0] out_pc,
    output logic [1:0]     out_len,
    output logic [3:0]     out_aluop,
    output logic           out_isaluop,
    output logic [1:0]     out_stackargs,
    output logic           out_stackwb,
    output logic           out_constpush,
    output logic [OPW-1:0] out_operand,
    output logic [7:0]     out_argidx,
    output logic           out_illegal
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    state_e         r_state, w_state_nx;
    logic [PCW-1:0] r_pc, r_op_pc, w_op_pc, w_head_pc;
    logic [7:0]     r_op, r_b1, w_op, w_b1;
    logic           w_hs, w_done, w_push, w_pop;
    op_class_t      w_cls;
    decode_rec_t    w_rec, w_head;
    logic [OPW-1:0] w_operand, w_head_opd;

    decode_rec_t    r_rec [DEPTH];
    logic [OPW-1:0] r_opd [DEPTH];
    logic [PCW-1:0] r_pcm [DEPTH];
    logic [AW-1:0]  r_wp, r_rp;
    logic [AW:0]    r_count;

    // The record is completed on the handshake edge, so decode from the live byte.
    assign w_op    = (r_state == S_OP) ? in_byte : r_op;
    assign w_b1    = (r_state == S_ARG1) ? in_byte : r_b1;
    assign w_op_pc = (r_state == S_OP) ? r_pc : r_op_pc;

    assign in_ready  = !rst && !flush && (r_count < FULL);
    assign out_valid = (r_count != '0);
    assign w_hs      = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    opcode_table u_table (
        .i_opcode (w_op),
        .o_class  (w_cls)
    );

    always_comb begin
        w_done = (r_state == S_ARG2) || (r_state == S_ARG1 && w_cls.argc == 2'd1) ||
                 (r_state == S_OP && w_cls.argc == 2'd0);
        w_push = w_hs && w_done;
        w_state_nx = !w_hs ? r_state : w_done ? S_OP : (r_state == S_OP) ? S_ARG1 : S_ARG2;
        w_operand = (w_cls.kind == OK_SEXT8)  ? OPW'($signed(w_b1)) :
                    (w_cls.kind == OK_SEXT16) ? OPW'($signed({w_b1, in_byte})) :
                    (w_cls.kind == OK_ZEXT8)  ? OPW'(w_b1) :
                    (w_cls.kind == OK_IINC)   ? OPW'($signed(in_byte)) :
                    (w_cls.kind == OK_CONST)  ? OPW'($signed(w_cls.cval)) : '0;
        w_rec = '0;
        w_rec.opcode    = w_op;
        w_rec.len       = w_cls.argc + 2'd1;
        w_rec.aluop     = w_cls.aluop;
        w_rec.isaluop   = w_cls.isaluop;
        w_rec.stackargs = w_cls.stackargs;
        w_rec.stackwb   = w_cls.stackwb;
        w_rec.constpush = w_cls.constpush;
        w_rec.illegal   = !w_cls.legal;
        w_rec.argidx    = (w_cls.kind == OK_IDX || w_cls.kind == OK_IINC) ? w_b1 :
                          (w_cls.kind == OK_IDXN) ? {6'd0, w_cls.idx_n} : 8'd0;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_state <= S_OP;
            r_pc    <= rst ? '0 : flush_pc;
            r_op    <= '0;
            r_op_pc <= '0;
            r_b1    <= '0;
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nx;
            if (w_hs) begin
                r_pc <= r_pc + 1'b1;
                if (r_state == S_OP) begin
                    r_op    <= in_byte;
                    r_op_pc <= r_pc;
                end
                if (r_state == S_ARG1) r_b1 <= in_byte;
            end
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rec[r_wp] <= w_rec;
            r_opd[r_wp] <= w_operand;
            r_pcm[r_wp] <= w_op_pc;
        end
    end

    assign w_head     = out_valid ? r_rec[r_rp] : '0;
    assign w_head_opd = out_valid ? r_opd[r_rp] : '0;
    assign w_head_pc  = out_valid ? r_pcm[r_rp] : '0;

    assign out_opcode    = w_head.opcode;
    assign out_pc        = w_head_pc;
    assign out_len       = w_head.len;
    assign out_aluop     = w_head.aluop;
    assign out_isaluop   = w_head.isaluop;
    assign out_stackargs = w_head.stackargs;
    assign out_stackwb   = w_head.stackwb;
    assign out_constpush = w_head.constpush;
    assign out_operand   = w_head_opd;
    assign out_argidx    = w_head.argidx;
    assign out_illegal   = w_head.illegal;

endmodule

// File: tb/tb_bytecode_decode_stage.sv
// tb_bytecode_decode_stage: directed plan scenarios plus randomized traffic
// checked against an instruction-level reference model.
module tb_bytecode_decode_stage;

    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
    logic [7:0]  in_byte = 8'h00;
    logic [15:0] flush_pc = 16'h0;
    logic        in_ready, out_valid, out_isaluop, out_stackwb, out_constpush, out_illegal;
    logic [7:0]  out_opcode, out_argidx;
    logic [15:0] out_pc;
    logic [1:0]  out_len, out_stackargs;
    logic [3:0]  out_aluop;
    logic [31:0] out_operand;

    typedef struct packed {
        logic [7:0]  op;
        logic [15:0] pc;
        logic [1:0]  len;
        logic [3:0]  alu;
        logic        isalu;
        logic [1:0]  sa;
        logic        wb;
        logic        cp;
        logic [31:0] opd;
        logic [7:0]  idx;
        logic        ill;
    } rec_t;

    rec_t        act;
    rec_t        q[$];
    rec_t        popped[$];
    logic [7:0]  cur[$];
    logic [15:0] mpc = 16'h0, cur_pc = 16'h0;
    int          errs = 0, checks = 0;
    logic [7:0]  pool [24] = '{8'h00, 8'h02, 8'h05, 8'h08, 8'h10, 8'h11, 8'h12, 8'h15, 8'h1b,
                               8'h2d, 8'h2e, 8'h36, 8'h3c, 8'h4e, 8'h4f, 8'h59, 8'h60, 8'h6c,
                               8'h74, 8'h7a, 8'h84, 8'h9b, 8'ha2, 8'ha7};

    bytecode_decode_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
        .flush(flush), .flush_pc(flush_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_pc(out_pc), .out_len(out_len), .out_aluop(out_aluop),
        .out_isaluop(out_isaluop), .out_stackargs(out_stackargs), .out_stackwb(out_stackwb),
        .out_constpush(out_constpush), .out_operand(out_operand), .out_argidx(out_argidx),
        .out_illegal(out_illegal)
    );

    assign act = {out_opcode, out_pc, out_len, out_aluop, out_isaluop, out_stackargs,
                  out_stackwb, out_constpush, out_operand, out_argidx, out_illegal};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int ref_argc(input logic [7:0] op);
        if (op inside {8'h10, 8'h12, 8'h15, 8'h36}) return 1;
        if (op inside {8'h11, 8'h84, 8'ha7, [8'h99:8'ha4]}) return 2;
        return 0;
    endfunction

    function automatic rec_t ref_rec(input logic [7:0] op, b1, b2, input logic [15:0] pc);
        rec_t r;
        logic [31:0] s16;
        r = '0;
        r.op = op;
        r.pc = pc;
        r.len = 2'(ref_argc(op) + 1);
        s16 = {{16{b1[7]}}, b1, b2};
        if (op >= 8'h02 && op <= 8'h08) begin r.opd = 32'(int'(op) - 3); r.cp = 1; r.wb = 1; end
        else if (op == 8'h10) begin r.opd = {{24{b1[7]}}, b1}; r.cp = 1; r.wb = 1; end
        else if (op == 8'h11) begin r.opd = s16; r.cp = 1; r.wb = 1; end
        else if (op == 8'h12) begin r.opd = {24'd0, b1}; r.wb = 1; end
        else if (op == 8'h15) begin r.idx = b1; r.wb = 1; end
        else if (op inside {[8'h1a:8'h1d]}) begin r.idx = op - 8'h1a; r.wb = 1; end
        else if (op inside {[8'h2a:8'h2d]}) begin r.idx = op - 8'h2a; r.wb = 1; end
        else if (op inside {8'h2e, 8'h33}) begin r.sa = 2; r.wb = 1; end
        else if (op == 8'h36) begin r.idx = b1; r.sa = 1; end
        else if (op inside {[8'h3b:8'h3e]}) begin r.idx = op - 8'h3b; r.sa = 1; end
        else if (op inside {[8'h4b:8'h4e]}) begin r.idx = op - 8'h4b; r.sa = 1; end
        else if (op inside {8'h4f, 8'h54}) r.sa = 3;
        else if (op inside {8'h57, 8'hac, 8'hb0}) r.sa = 1;
        else if (op == 8'h59) begin r.sa = 1; r.wb = 1; end
        else if (op inside {8'h60, 8'h64, 8'h68, 8'h6c, 8'h70}) begin
            r.sa = 2; r.wb = 1; r.isalu = 1; r.alu = 4'((op - 8'h60) >> 2);
        end
        else if (op == 8'h74) begin r.sa = 1; r.wb = 1; r.isalu = 1; r.alu = 4'd5; end
        else if (op inside {8'h78, 8'h7a, 8'h7e, 8'h80, 8'h82}) begin
            r.sa = 2; r.wb = 1; r.isalu = 1;
            r.alu = (op == 8'h78) ? 4'hc : (op == 8'h7a) ? 4'hd : (op == 8'h7e) ? 4'hf :
                    (op == 8'h80) ? 4'h8 : 4'h9;
        end
        else if (op == 8'h84) begin r.idx = b1; r.opd = {{24{b2[7]}}, b2}; r.isalu = 1; end
        else if (op inside {[8'h99:8'h9e]}) begin r.sa = 1; r.opd = s16; end
        else if (op inside {[8'h9f:8'ha4]}) begin r.sa = 2; r.opd = s16; end
        else if (op == 8'ha7) r.opd = s16;
        else if (op != 8'h00) r.ill = 1;
        return r;
    endfunction

    task automatic accept(input logic [7:0] b);
        if (cur.size() == 0) cur_pc = mpc;
        cur.push_back(b);
        if (cur.size() == ref_argc(cur[0]) + 1) begin
            q.push_back(ref_rec(cur[0], cur.size() > 1 ? cur[1] : 8'h0,
                                cur.size() > 2 ? cur[2] : 8'h0, cur_pc));
            cur.delete();
        end
        mpc = mpc + 16'd1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            cur.delete();
            mpc = 16'h0;
        end else begin
            chk("in_ready", in_ready, !flush && q.size() < 4);
            chk("out_valid", out_valid, q.size() != 0);
            if (q.size() != 0) chk("record", act, q[0]);
            if (flush) begin
                q.delete();
                cur.delete();
                mpc = flush_pc;
            end else begin
                if (out_valid && out_ready) begin
                    popped.push_back(act);
                    if (q.size() != 0) void'(q.pop_front());
                end
                if (in_valid && in_ready) accept(in_byte);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", in_ready, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_fields", act, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        popped.delete();
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_byte = b;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                chk("send_timeout", in_ready, 1);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (6) @(posedge clk);
        #1;
    endtask

    initial begin
        do_reset();
        send(8'h04); send(8'h05); send(8'h60); settle();
        chk("t1_count", popped.size(), 3);
        if (popped.size() == 3) begin
            chk("t1_pc", {popped[0].pc, popped[1].pc, popped[2].pc}, {16'd0, 16'd1, 16'd2});
            chk("t1_opd", {popped[0].opd, popped[1].opd}, {32'd1, 32'd2});
            chk("t1_add", {popped[2].alu, popped[2].sa, popped[2].wb}, {4'd0, 2'd2, 1'b1});
            chk("t1_len", {popped[0].len, popped[1].len, popped[2].len}, {2'd1, 2'd1, 2'd1});
        end

        do_reset();
        send(8'h10); send(8'hfe); send(8'h11); send(8'h80); send(8'h00); settle();
        chk("t2_count", popped.size(), 2);
        if (popped.size() == 2) begin
            chk("t2_bipush", {popped[0].opd, popped[0].len, popped[0].pc}, {32'hfffffffe, 2'd2, 16'd0});
            chk("t2_sipush", {popped[1].opd, popped[1].len, popped[1].pc}, {32'hffff8000, 2'd3, 16'd2});
        end

        do_reset();
        send(8'h84); send(8'h03); send(8'hff); send(8'ha7); send(8'h00); send(8'h10); settle();
        chk("t3_count", popped.size(), 2);
        if (popped.size() == 2) begin
            chk("t3_iinc", {popped[0].idx, popped[0].opd, popped[0].isalu}, {8'd3, 32'hffffffff, 1'b1});
            chk("t3_goto", {popped[1].opd, popped[1].pc, popped[1].len}, {32'd16, 16'd3, 2'd3});
        end

        do_reset();
        out_ready = 1'b0;
        send(8'h02); send(8'h03); send(8'h04); send(8'h05);
        in_valid = 1'b1;
        in_byte = 8'h06;
        repeat (3) begin
            @(negedge clk);
            chk("t4_stall", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(8'h06); send(8'h07); settle();
        chk("t4_count", popped.size(), 6);
        if (popped.size() == 6)
            for (int i = 0; i < 6; i++) chk("t4_order", popped[i].op, 8'(i + 2));

        do_reset();
        send(8'ha7); send(8'h00);
        flush = 1'b1; flush_pc = 16'h0040; in_valid = 1'b1; in_byte = 8'h10;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("t5_empty", out_valid, 0);
        @(posedge clk); #1;
        send(8'h03); settle();
        chk("t5_count", popped.size(), 1);
        if (popped.size() == 1) chk("t5_rec", {popped[0].op, popped[0].pc}, {8'h03, 16'h0040});

        do_reset();
        send(8'hff); send(8'h04); settle();
        chk("t6_count", popped.size(), 2);
        if (popped.size() == 2) begin
            chk("t6_ill", {popped[0].ill, popped[0].len, popped[0].opd, popped[0].idx, popped[0].sa, popped[0].wb},
                {1'b1, 2'd1, 32'd0, 8'd0, 2'd0, 1'b0});
            chk("t6_next", {popped[1].op, popped[1].pc, popped[1].ill, popped[1].opd},
                {8'h04, 16'd1, 1'b0, 32'd1});
        end

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            in_valid = ($urandom_range(3) != 0);
            in_byte = ($urandom_range(3) != 0) ? pool[$urandom_range(23)] : 8'($urandom);
            out_ready = ($urandom_range(3) != 0);
            flush = ($urandom_range(63) == 0);
            flush_pc = $urandom_range(1) ? 16'hfffc : 16'($urandom);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("drain", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
